control_modo_rtc: RTL
=====================

Name: control_modo_rtc

Overview:
- Mode controller and RTC-bus scheduler for the clock/date/timer configuration datapath.
- Turns the three configuration switches into the 3-bit configuration code that drives the counter bank: 0 normal, 1 hora, 2 fecha, 4 timer.
- In normal mode it issues a periodic read burst over the RTC register bus.
- On leaving a configuration mode it writes that group's three edited bytes back to the RTC, one bus transfer at a time.

Parameters:
- READ_PERIOD, 100000, clock cycles from the end of one read burst (or from reset) to the start of the next; minimum 4.
- CW, 17, width of the period counter; must satisfy 2^CW > READ_PERIOD.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sw_hora  in  1  level switch, request clock configuration
- sw_fecha  in  1  level switch, request date configuration
- sw_timer  in  1  level switch, request timer configuration
- data_SS, data_MM, data_HH  in  8 each  edited time bytes from the counter bank
- data_YEAR, data_MES, data_DAY  in  8 each  edited date bytes
- data_SS_T, data_MM_T, data_HH_T  in  8 each  edited timer bytes
- configuracion  out  3  mode code to the counter bank
- bus_req  out  1  transfer request to the RTC bus master
- bus_wr  out  1  1 = write, 0 = read
- bus_addr  out  8  RTC register address
- bus_wdata  out  8  write data
- bus_done  in  1  one-cycle completion pulse from the bus master
- busy  out  1  high while a burst is in progress

Behaviour:
- Reset values: configuracion=0, bus_req=0, bus_wr=0, bus_addr=0, bus_wdata=0, busy=0. Period counter, edge registers, pending flags and index all clear; state=NORMAL.
- Address map:
  - SS 0x21, MM 0x22, HH 0x23, DAY 0x24, MES 0x25, YEAR 0x26
  - SS_T 0x41, MM_T 0x42, HH_T 0x43
- Switch edges: each switch is registered once; rise = sw & ~sw_q. A rise sets that group's pending flag. Pending flags are cleared on entering CONFIG or on reset.
- Priority on simultaneous pending flags: hora > fecha > timer. The losers are cleared.
- States:
  - NORMAL
    - configuracion=0; period counter increments.
    - If any pending flag is set: go to CONFIG next cycle. The pending request wins over a period expiry in the same cycle.
    - Else when counter == READ_PERIOD-1: go to RD_BURST with index=0, counter cleared.
  - RD_BURST
    - busy=1, bus_wr=0. Reads 9 registers in order 0x21..0x26, then 0x41..0x43.
    - Rises arriving here only set pending; they are serviced in NORMAL after the burst.
  - CONFIG
    - configuracion = 1/2/4 per the selected group; period counter frozen.
    - Other switches' rises are ignored and not latched.
    - When the selected switch reads 0: snapshot its three data inputs into internal registers, go to WR_BURST, index=0.
  - WR_BURST
    - busy=1, bus_wr=1, configuracion=0 from the first WR_BURST cycle.
    - Writes the snapshot in order: hora SS,MM,HH; fecha DAY,MES,YEAR; timer SS_T,MM_T,HH_T.
    - After the third bus_done: go to NORMAL with the period counter cleared.
- Handshake, per transfer:
  - bus_req rises with bus_addr/bus_wr/bus_wdata already valid. All four stay stable until the cycle bus_done=1 is sampled.
  - bus_req goes low the cycle after bus_done and stays low at least 1 cycle. The next transfer's bus_req rises 2 cycles after the previous bus_done.
  - bus_done while bus_req=0 is ignored. No timeout; the controller waits indefinitely.
- Write data comes only from the snapshot. Counter-bank changes during WR_BURST have no effect.
- Reset mid-burst: everything returns to reset values the next cycle. The partial burst is abandoned and not resumed.
- Index is 4 bits and never exceeds 8 (read) or 2 (write). The period counter saturates-compares and never wraps past READ_PERIOD-1.

Decomposition:
- Shared package: mode codes (MODO_NORMAL=0, MODO_HORA=1, MODO_FECHA=2, MODO_TIMER=4), the nine RTC address constants, and the state encoding.
- One sub-module, rtc_bus_xfer: single-transfer handshake engine. Inputs: start, wr, addr, wdata, bus_done. Outputs: bus_* and a done pulse.
- The top FSM sequences indices and modes.

Test Plan:
- Reset, READ_PERIOD=8, bus_done returned 2 cycles after each bus_req -> first bus_req at cycle 8 with addr 0x21, bus_wr=0. Nine transfers appear in the specified order; busy falls after the 0x43 done.
- sw_hora 0->1 in NORMAL -> configuracion=1 two cycles later. Set data_SS=0x45, MM=0x30, HH=0x12, drop sw_hora -> configuracion=0 and writes (0x21,0x45), (0x22,0x30), (0x23,0x12).
- sw_fecha and sw_timer rise in the same cycle -> configuracion=2. Dropping sw_timer does nothing; dropping sw_fecha writes 0x24, 0x25, 0x26.
- sw_timer rises during the 4th read transfer -> read burst completes all 9 transfers, then configuracion=4.
- Change data_HH_T after WR_BURST starts -> written value equals the pre-exit snapshot.
- Assert reset while bus_req=1 in the 2nd write -> next cycle all outputs 0, state NORMAL. The next read begins READ_PERIOD cycles after reset is released.

Source files
------------

// File: rtl/control_modo_rtc_pkg.sv
// Shared definitions for the mode controller / RTC bus scheduler.
//   - mode codes driven to the counter bank
//   - RTC register addresses for the time, date and timer groups
//   - FSM state and configuration-group encodings
//   - address lookup helpers for the read and write bursts
package control_modo_rtc_pkg;

    localparam logic [2:0] MODO_NORMAL = 3'd0;
    localparam logic [2:0] MODO_HORA   = 3'd1;
    localparam logic [2:0] MODO_FECHA  = 3'd2;
    localparam logic [2:0] MODO_TIMER  = 3'd4;

    localparam logic [7:0] ADDR_SS   = 8'h21;
    localparam logic [7:0] ADDR_MM   = 8'h22;
    localparam logic [7:0] ADDR_HH   = 8'h23;
    localparam logic [7:0] ADDR_DAY  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_YEAR = 8'h26;
    localparam logic [7:0] ADDR_SS_T = 8'h41;
    localparam logic [7:0] ADDR_MM_T = 8'h42;
    localparam logic [7:0] ADDR_HH_T = 8'h43;

    localparam logic [3:0] RD_LAST_IDX = 4'd8;
    localparam logic [3:0] WR_LAST_IDX = 4'd2;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_CONFIG   = 2'd1,
        ST_RD_BURST = 2'd2,
        ST_WR_BURST = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GRP_HORA  = 2'd0,
        GRP_FECHA = 2'd1,
        GRP_TIMER = 2'd2
    } grupo_t;

    // Read burst order: 0x21..0x26 then 0x41..0x43.
    function automatic logic [7:0] rd_addr(input logic [3:0] idx);
        logic [7:0] a;
        case (idx)
            4'd0:    a = ADDR_SS;
            4'd1:    a = ADDR_MM;
            4'd2:    a = ADDR_HH;
            4'd3:    a = ADDR_DAY;
            4'd4:    a = ADDR_MES;
            4'd5:    a = ADDR_YEAR;
            4'd6:    a = ADDR_SS_T;
            4'd7:    a = ADDR_MM_T;
            4'd8:    a = ADDR_HH_T;
            default: a = ADDR_SS;
        endcase
        return a;
    endfunction

    // Write-back order per group; the date group goes DAY, MES, YEAR.
    function automatic logic [7:0] wr_addr(input grupo_t g, input logic [3:0] idx);
        logic [7:0] a;
        case (g)
            GRP_HORA:  a = (idx == 4'd0) ? ADDR_SS  : (idx == 4'd1) ? ADDR_MM  : ADDR_HH;
            GRP_FECHA: a = (idx == 4'd0) ? ADDR_DAY : (idx == 4'd1) ? ADDR_MES : ADDR_YEAR;
            default:   a = (idx == 4'd0) ? ADDR_SS_T : (idx == 4'd1) ? ADDR_MM_T : ADDR_HH_T;
        endcase
        return a;
    endfunction

    function automatic logic [2:0] modo_de(input grupo_t g);
        logic [2:0] m;
        case (g)
            GRP_HORA:  m = MODO_HORA;
            GRP_FECHA: m = MODO_FECHA;
            default:   m = MODO_TIMER;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/control_modo_rtc_if.sv
// RTC register bus between the mode controller (master) and the RTC bus
// engine (slave).
//   bus_req   master -> slave  transfer request
//   bus_wr    master -> slave  1 = write, 0 = read
//   bus_addr  master -> slave  RTC register address
//   bus_wdata master -> slave  write data
//   bus_done  slave -> master  one-cycle completion pulse
interface control_modo_rtc_if;
    logic       bus_req;
    logic       bus_wr;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_done;

    modport master (
        output bus_req,
        output bus_wr,
        output bus_addr,
        output bus_wdata,
        input  bus_done
    );

    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_addr,
        input  bus_wdata,
        output bus_done
    );
endinterface

// File: rtl/control_modo_rtc_bus_xfer.sv
// rtc_bus_xfer: single-transfer handshake engine.
// A start while idle latches wr/addr/wdata and raises bus_req in the same
// edge, so the bus fields are valid the first cycle bus_req is seen. They
// hold until bus_done is sampled; bus_req then drops for at least one cycle.
// bus_done while idle is ignored.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               request a transfer (taken only while idle)
//   wr, addr, wdata     transfer fields
//   bus_done            completion pulse from the bus master
//   bus_req, bus_wr,
//   bus_addr, bus_wdata registered bus outputs
//   done                completion of the current transfer (combinational)
module rtc_bus_xfer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       bus_done,
    output logic       bus_req,
    output logic       bus_wr,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       done
);

    assign done = bus_req & bus_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
        end else if (bus_req) begin
            if (bus_done) begin
                bus_req <= 1'b0;
            end
        end else if (start) begin
            bus_req   <= 1'b1;
            bus_wr    <= wr;
            bus_addr  <= addr;
            bus_wdata <= wdata;
        end
    end

endmodule

// File: rtl/control_modo_rtc.sv
// control_modo_rtc: mode controller and RTC bus scheduler.
// Maps the hora/fecha/timer switches to the counter-bank configuration
// code, runs a periodic 9-register read burst in normal mode, and writes the
// edited group back to the RTC when its switch is released.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   sw_hora, sw_fecha, sw_timer    configuration request switches (levels)
//   data_*                         edited bytes from the counter bank
//   configuracion                  mode code (0 normal, 1 hora, 2 fecha, 4 timer)
//   busy                           high during a read or write burst
//   bus                            RTC register bus (master side)
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_NORMAL   | period counter running; waits for a request or expiry
// ST_CONFIG   | one group being edited; counter frozen
// ST_RD_BURST | reading 0x21..0x26, 0x41..0x43
// ST_WR_BURST | writing the snapshot of the edited group
module control_modo_rtc
    import control_modo_rtc_pkg::*;
#(
    parameter int READ_PERIOD = 100000,
    parameter int CW          = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_hora,
    input  logic       sw_fecha,
    input  logic       sw_timer,
    input  logic [7:0] data_SS,
    input  logic [7:0] data_MM,
    input  logic [7:0] data_HH,
    input  logic [7:0] data_YEAR,
    input  logic [7:0] data_MES,
    input  logic [7:0] data_DAY,
    input  logic [7:0] data_SS_T,
    input  logic [7:0] data_MM_T,
    input  logic [7:0] data_HH_T,
    output logic [2:0] configuracion,
    output logic       busy,
    control_modo_rtc_if.master bus
);

    localparam logic [CW-1:0] CNT_LAST = CW'(READ_PERIOD - 1);

    state_t        state;
    grupo_t        grupo;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic [2:0]    sw_q;
    logic [2:0]    pend;
    logic [7:0]    snap0, snap1, snap2;

    logic [2:0]    sw_vec;
    logic [2:0]    rise;
    grupo_t        sel;
    logic          sw_sel;
    logic [7:0]    live0, live1, live2;
    logic [7:0]    snap_cur;

    logic          xfer_start, xfer_wr, xfer_done, xfer_req;
    logic [7:0]    xfer_addr, xfer_wdata;

    // bit 0 hora, bit 1 fecha, bit 2 timer
    assign sw_vec = {sw_timer, sw_fecha, sw_hora};
    assign rise   = sw_vec & ~sw_q;

    always_comb begin
        sel = GRP_TIMER;
        if (pend[0]) begin
            sel = GRP_HORA;
        end else if (pend[1]) begin
            sel = GRP_FECHA;
        end
    end

    always_comb begin
        sw_sel = sw_timer;
        live0  = data_SS_T;
        live1  = data_MM_T;
        live2  = data_HH_T;
        case (grupo)
            GRP_HORA: begin
                sw_sel = sw_hora;
                live0  = data_SS;
                live1  = data_MM;
                live2  = data_HH;
            end
            GRP_FECHA: begin
                sw_sel = sw_fecha;
                live0  = data_DAY;
                live1  = data_MES;
                live2  = data_YEAR;
            end
            default: ;
        endcase
    end

    always_comb begin
        snap_cur = snap2;
        if (idx == 4'd0) begin
            snap_cur = snap0;
        end else if (idx == 4'd1) begin
            snap_cur = snap1;
        end
    end

    // Each transfer is launched while the engine is idle. The first one of a
    // burst is launched on the transition edge so bus_req appears in the
    // first burst cycle; the CONFIG exit uses live data equal to the value
    // being snapshotted on that same edge.
    always_comb begin
        xfer_start = 1'b0;
        xfer_wr    = 1'b0;
        xfer_addr  = 8'h00;
        xfer_wdata = 8'h00;
        case (state)
            ST_NORMAL: begin
                if (pend == 3'b000 && cnt == CNT_LAST) begin
                    xfer_start = 1'b1;
                    xfer_addr  = rd_addr(4'd0);
                end
            end
            ST_RD_BURST: begin
                if (!xfer_req) begin
                    xfer_start = 1'b1;
                    xfer_addr  = rd_addr(idx);
                end
            end
            ST_CONFIG: begin
                if (!sw_sel) begin
                    xfer_start = 1'b1;
                    xfer_wr    = 1'b1;
                    xfer_addr  = wr_addr(grupo, 4'd0);
                    xfer_wdata = live0;
                end
            end
            ST_WR_BURST: begin
                if (!xfer_req) begin
                    xfer_start = 1'b1;
                    xfer_wr    = 1'b1;
                    xfer_addr  = wr_addr(grupo, idx);
                    xfer_wdata = snap_cur;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_NORMAL;
            grupo         <= GRP_HORA;
            idx           <= 4'd0;
            cnt           <= '0;
            sw_q          <= 3'b000;
            pend          <= 3'b000;
            snap0         <= 8'h00;
            snap1         <= 8'h00;
            snap2         <= 8'h00;
            configuracion <= MODO_NORMAL;
            busy          <= 1'b0;
        end else begin
            sw_q <= sw_vec;
            if (state != ST_CONFIG) begin
                pend <= pend | rise;
            end
            case (state)
                ST_NORMAL: begin
                    configuracion <= MODO_NORMAL;
                    busy          <= 1'b0;
                    if (pend != 3'b000) begin
                        // Losing requests are dropped along with the winner's flag.
                        state         <= ST_CONFIG;
                        grupo         <= sel;
                        configuracion <= modo_de(sel);
                        pend          <= 3'b000;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_RD_BURST;
                        idx   <= 4'd0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RD_BURST: begin
                    if (xfer_done) begin
                        if (idx == RD_LAST_IDX) begin
                            state <= ST_NORMAL;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_CONFIG: begin
                    if (!sw_sel) begin
                        snap0         <= live0;
                        snap1         <= live1;
                        snap2         <= live2;
                        state         <= ST_WR_BURST;
                        idx           <= 4'd0;
                        busy          <= 1'b1;
                        configuracion <= MODO_NORMAL;
                    end
                end
                ST_WR_BURST: begin
                    if (xfer_done) begin
                        if (idx == WR_LAST_IDX) begin
                            state <= ST_NORMAL;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: state <= ST_NORMAL;
            endcase
        end
    end

    logic       xfer_wr_q;
    logic [7:0] xfer_addr_q, xfer_wdata_q;

    rtc_bus_xfer u_xfer (
        .clk       (clk),
        .reset     (reset),
        .start     (xfer_start),
        .wr        (xfer_wr),
        .addr      (xfer_addr),
        .wdata     (xfer_wdata),
        .bus_done  (bus.bus_done),
        .bus_req   (xfer_req),
        .bus_wr    (xfer_wr_q),
        .bus_addr  (xfer_addr_q),
        .bus_wdata (xfer_wdata_q),
        .done      (xfer_done)
    );

    assign bus.bus_req   = xfer_req;
    assign bus.bus_wr    = xfer_wr_q;
    assign bus.bus_addr  = xfer_addr_q;
    assign bus.bus_wdata = xfer_wdata_q;

endmodule
